// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter: FSM state encoding,
// port-owner encoding, default address/data widths and the wait-counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    // Wide enough for the largest legal memory latency (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_IFETCH = 2'd1,
        OWN_DATA   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_wait_cnt.sv
// -----------------------------------------------------------------------------
// mem_port_wait_cnt
// Loadable down-counter with a terminal flag, used to time memory wait states.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (count -> 0)
//   load     in   load load_val (has priority over dec)
//   dec      in   decrement by one, holding at zero
//   load_val in   value loaded on load
//   count    out  current count
//   last     out  count == 1, i.e. this is the final wait cycle
// -----------------------------------------------------------------------------
module mem_port_wait_cnt
    import mem_port_arbiter_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port unified memory between instruction fetch and data
// access. Data has fixed priority; one access is in flight at a time and the
// pipeline is stalled while any request is waiting for its ready pulse.
// Sequence per access: IDLE (grant) -> ACCESS (MEM_LATENCY cycles) -> DONE
// (one-cycle ready) -> IDLE.
//
// Ports:
//   clock, reset             clock and synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ready) and address
//   if_rdata/if_ready        fetched word and one-cycle completion pulse
//   d_read/d_write           data read/write requests (held until d_ready)
//   d_addr/d_wdata           data address and store data
//   d_rdata/d_ready          load data and one-cycle completion pulse
//   mem_en/mem_we            memory enable / write enable
//   mem_addr/mem_wdata       memory address / write data
//   mem_rdata                memory read data, sampled on the last wait cycle
//   stall                    freeze PC and pipeline registers
//
// Optional build macro MEM_PORT_ARB_PERF_EN adds saturating 16-bit counters
//   perf_if_cnt, perf_d_cnt, perf_stall_cnt (fetches, data accesses, stall
//   cycles), all cleared by reset.
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,
    input  logic          d_read,
    input  logic          d_write,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    output logic [15:0]   perf_if_cnt,
    output logic [15:0]   perf_d_cnt,
    output logic [15:0]   perf_stall_cnt
`endif
);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic             grant;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wdata_q;
    logic             we_q;
    logic [DW-1:0]    if_rdata_q;
    logic [DW-1:0]    d_rdata_q;
    logic [CNT_W-1:0] wait_count;
    logic             wait_last;

    mem_port_wait_cnt u_wait_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (grant),
        .dec      (state_q == ST_ACCESS),
        .load_val (CNT_W'(MEM_LATENCY)),
        .count    (wait_count),
        .last     (wait_last)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        grant     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_ready  = 1'b0;
        d_ready   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Data wins; a simultaneous read+write is granted as a write
                // because we_q latches d_write.
                if (d_read || d_write) begin
                    owner_d = OWN_DATA;
                    state_d = ST_ACCESS;
                    grant   = 1'b1;
                end else if (if_req) begin
                    owner_d = OWN_IFETCH;
                    state_d = ST_ACCESS;
                    grant   = 1'b1;
                end
            end
            ST_ACCESS: begin
                mem_en = 1'b1;
                mem_we = we_q;
                if (wait_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Requesters still hold their lines here; they are ignored
                // until IDLE so a finished access is not granted twice.
                if_ready = (owner_q == OWN_IFETCH);
                d_ready  = (owner_q == OWN_DATA);
                state_d  = ST_IDLE;
                owner_d  = OWN_NONE;
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase

        stall = (if_req | d_read | d_write) & ~if_ready & ~d_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (grant) begin
                if (owner_d == OWN_DATA) begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    we_q    <= d_write;
                end else begin
                    addr_q  <= if_addr;
                    wdata_q <= '0;
                    we_q    <= 1'b0;
                end
            end
            // Capture on the final wait cycle; for writes d_rdata simply
            // follows mem_rdata and carries no meaning.
            if ((state_q == ST_ACCESS) && wait_last) begin
                if (owner_q == OWN_DATA) begin
                    d_rdata_q <= mem_rdata;
                end else begin
                    if_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

`ifdef MEM_PORT_ARB_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_if_cnt    <= '0;
            perf_d_cnt     <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (if_ready && (perf_if_cnt != 16'hFFFF)) begin
                perf_if_cnt <= perf_if_cnt + 16'd1;
            end
            if (d_ready && (perf_d_cnt != 16'hFFFF)) begin
                perf_d_cnt <= perf_d_cnt + 16'd1;
            end
            if (stall && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A 16-word memory model answers the
// DUT's memory port; a transaction-level reference (ordered access list with
// predicted grant/ready cycles and a shadow memory) gives every expected value.
// Define MEM_PORT_ARB_PERF_EN to also exercise the performance counters.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int L  = 3;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall;
`ifdef MEM_PORT_ARB_PERF_EN
    logic [15:0]   perf_if_cnt;
    logic [15:0]   perf_d_cnt;
    logic [15:0]   perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Physical memory driven only by the DUT port (plus a preload path);
    // model_mem is the bench's shadow copy updated at transaction level.
    logic [DW-1:0] phys_mem  [16];
    logic [DW-1:0] model_mem [16];
    logic          pre_we;
    logic [3:0]    pre_idx;
    logic [DW-1:0] pre_data;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .MEM_LATENCY (L),
        .AW          (AW),
        .DW          (DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
`ifdef MEM_PORT_ARB_PERF_EN
        ,
        .perf_if_cnt    (perf_if_cnt),
        .perf_d_cnt     (perf_d_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    assign mem_rdata = phys_mem[mem_addr[3:0]];

    always @(posedge clock) begin
        if (mem_en && mem_we) begin
            phys_mem[mem_addr[3:0]] <= mem_wdata;
        end else if (pre_we) begin
            phys_mem[pre_idx] <= pre_data;
        end
    end

    task automatic preload(input int idx, input logic [DW-1:0] v);
        @(posedge clock); #1;
        pre_we         = 1'b1;
        pre_idx        = idx[3:0];
        pre_data       = v;
        model_mem[idx] = v;
        @(posedge clock); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset   = 1'b1;
        if_req  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Drives one request pattern, holds each line until its ready pulse, and
    // scores every cycle against the predicted access schedule: access k is
    // granted at cycle k*(L+2), mem_en spans k*(L+2)+1 .. k*(L+2)+L and ready
    // pulses at k*(L+2)+L+1. Data is always served before fetch.
    task automatic run_txn(input string tag, input bit ir, input bit dr, input bit dw,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [DW-1:0] wd, input bit drop_early);
        bit            a_we    [2];
        logic [AW-1:0] a_addr  [2];
        logic [DW-1:0] a_wdata [2];
        logic [DW-1:0] a_rdata [2];
        int            n    = 0;
        int            r_d  = -1;
        int            r_if = -1;
        int            k_d  = 0;
        int            k_if = 0;
        int            k;
        int            last_c;
        bit            exp_en, exp_dr, exp_ir, exp_stall;

        if (dr || dw) begin
            a_we[n]    = dw;
            a_addr[n]  = da;
            a_wdata[n] = wd;
            a_rdata[n] = model_mem[da[3:0]];
            if (dw) model_mem[da[3:0]] = wd;
            k_d = n;
            r_d = n * (L + 2) + L + 1;
            n++;
        end
        if (ir) begin
            a_we[n]    = 1'b0;
            a_addr[n]  = ia;
            a_wdata[n] = '0;
            a_rdata[n] = model_mem[ia[3:0]];
            k_if = n;
            r_if = n * (L + 2) + L + 1;
            n++;
        end
        last_c = n * (L + 2);

        @(posedge clock); #1;
        if_req  = ir;
        d_read  = dr;
        d_write = dw;
        if_addr = ia;
        d_addr  = da;
        d_wdata = wd;

        for (int c = 0; c <= last_c; c++) begin
            @(negedge clock);
            exp_en = 1'b0;
            k      = 0;
            for (int j = 0; j < n; j++) begin
                if (c >= j * (L + 2) + 1 && c <= j * (L + 2) + L) begin
                    exp_en = 1'b1;
                    k      = j;
                end
            end
            exp_dr    = (c == r_d);
            exp_ir    = (c == r_if);
            exp_stall = (if_req | d_read | d_write) & ~exp_dr & ~exp_ir;

            checks++;
            if (mem_en !== exp_en) begin
                errors++;
                $display("FAIL %s mem_en cyc %0d got %b exp %b", tag, c, mem_en, exp_en);
            end
            if (exp_en) begin
                checks++;
                if (mem_addr !== a_addr[k]) begin
                    errors++;
                    $display("FAIL %s mem_addr cyc %0d got %h exp %h", tag, c, mem_addr, a_addr[k]);
                end
                checks++;
                if (mem_we !== a_we[k]) begin
                    errors++;
                    $display("FAIL %s mem_we cyc %0d got %b exp %b", tag, c, mem_we, a_we[k]);
                end
                if (a_we[k]) begin
                    checks++;
                    if (mem_wdata !== a_wdata[k]) begin
                        errors++;
                        $display("FAIL %s mem_wdata cyc %0d got %h exp %h", tag, c, mem_wdata, a_wdata[k]);
                    end
                end
            end
            checks++;
            if (d_ready !== exp_dr) begin
                errors++;
                $display("FAIL %s d_ready cyc %0d got %b exp %b", tag, c, d_ready, exp_dr);
            end
            checks++;
            if (if_ready !== exp_ir) begin
                errors++;
                $display("FAIL %s if_ready cyc %0d got %b exp %b", tag, c, if_ready, exp_ir);
            end
            if (exp_dr && !a_we[k_d]) begin
                checks++;
                if (d_rdata !== a_rdata[k_d]) begin
                    errors++;
                    $display("FAIL %s d_rdata got %h exp %h", tag, d_rdata, a_rdata[k_d]);
                end
            end
            if (exp_ir) begin
                checks++;
                if (if_rdata !== a_rdata[k_if]) begin
                    errors++;
                    $display("FAIL %s if_rdata got %h exp %h", tag, if_rdata, a_rdata[k_if]);
                end
            end
            checks++;
            if (stall !== exp_stall) begin
                errors++;
                $display("FAIL %s stall cyc %0d got %b exp %b", tag, c, stall, exp_stall);
            end

            @(posedge clock); #1;
            if (exp_dr) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
            if (exp_ir) if_req = 1'b0;
            if (drop_early && c == 0 && n == 1) begin
                if_req  = 1'b0;
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL rst mem_en got %b exp 0", mem_en); end
        checks++; if (mem_we !== 1'b0)   begin errors++; $display("FAIL rst mem_we got %b exp 0", mem_we); end
        checks++; if (mem_addr !== '0)   begin errors++; $display("FAIL rst mem_addr got %h exp 0", mem_addr); end
        checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rst if_ready got %b exp 0", if_ready); end
        checks++; if (d_ready !== 1'b0)  begin errors++; $display("FAIL rst d_ready got %b exp 0", d_ready); end
        checks++; if (if_rdata !== '0)   begin errors++; $display("FAIL rst if_rdata got %h exp 0", if_rdata); end
        checks++; if (d_rdata !== '0)    begin errors++; $display("FAIL rst d_rdata got %h exp 0", d_rdata); end
        checks++; if (stall !== 1'b0)    begin errors++; $display("FAIL rst stall got %b exp 0", stall); end
    endtask

    task automatic test_fetch();
        preload(0, 16'h3A45);
        run_txn("fetch", 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_priority();
        preload(2, 16'h55AA);
        preload(3, 16'h0F0F);
        run_txn("prio", 1'b1, 1'b1, 1'b0, 16'h0033, 16'h0202, 16'h0000, 1'b0);
    endtask

    task automatic test_write();
        run_txn("write", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0040, 16'hBEEF, 1'b0);
        run_txn("readback", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 1'b0);
        run_txn("rdwr", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0045, 16'h1234, 1'b0);
        run_txn("rdwr_back", 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_drop();
        run_txn("drop_if", 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000, 16'h0000, 1'b1);
        run_txn("drop_d", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0009, 16'h0000, 1'b1);
    endtask

    task automatic test_reset_mid_access();
        @(posedge clock); #1;
        if_req  = 1'b1;
        if_addr = 16'h0022;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset  = 1'b0;
        if_req = 1'b0;
        for (int c = 0; c < L + 3; c++) begin
            @(negedge clock);
            checks++; if (mem_en !== 1'b0)   begin errors++; $display("FAIL rstmid mem_en cyc %0d got %b exp 0", c, mem_en); end
            checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL rstmid if_ready cyc %0d got %b exp 0", c, if_ready); end
            checks++; if (d_ready !== 1'b0)  begin errors++; $display("FAIL rstmid d_ready cyc %0d got %b exp 0", c, d_ready); end
            @(posedge clock); #1;
        end
        checks++;
        if (if_rdata !== '0) begin
            errors++;
            $display("FAIL rstmid if_rdata got %h exp 0", if_rdata);
        end
        run_txn("after_rst", 1'b1, 1'b0, 1'b0, 16'h0022, 16'h0000, 16'h0000, 1'b0);
    endtask

    task automatic test_random();
        bit ir, dr, dw, drop;
        int gap;
        for (int t = 0; t < 40; t++) begin
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ir && !dr && !dw) ir = 1'b1;
            drop = ((32'(ir) + 32'(dr | dw)) == 1) && ($urandom_range(0, 3) == 0);
            run_txn("rand", ir, dr, dw, 16'($urandom), 16'($urandom), 16'($urandom), drop);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clock);
                checks++;
                if (mem_en !== 1'b0 || stall !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle got en=%b stall=%b exp 0 0", mem_en, stall);
                end
            end
        end
    endtask

`ifdef MEM_PORT_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 3; i++)
            run_txn("perf_if", 1'b1, 1'b0, 1'b0, 16'(i), 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 2; i++)
            run_txn("perf_d", 1'b0, 1'b1, 1'b0, 16'h0000, 16'(i + 4), 16'h0000, 1'b0);
        @(negedge clock);
        checks++; if (perf_if_cnt !== 16'd3) begin errors++; $display("FAIL perf_if_cnt got %0d exp 3", perf_if_cnt); end
        checks++; if (perf_d_cnt !== 16'd2)  begin errors++; $display("FAIL perf_d_cnt got %0d exp 2", perf_d_cnt); end
        checks++;
        if (perf_stall_cnt !== 16'(5 * (L + 1))) begin
            errors++;
            $display("FAIL perf_stall_cnt got %0d exp %0d", perf_stall_cnt, 5 * (L + 1));
        end
    endtask
`endif

    initial begin
        logic [DW-1:0] v;
        reset    = 1'b1;
        if_req   = 1'b0;
        d_read   = 1'b0;
        d_write  = 1'b0;
        if_addr  = '0;
        d_addr   = '0;
        d_wdata  = '0;
        pre_we   = 1'b0;
        pre_idx  = '0;
        pre_data = '0;
        for (int i = 0; i < 16; i++) begin
            v = 16'($urandom);
            preload(i, v);
        end

        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_drop();
        test_reset_mid_access();
        test_random();
`ifdef MEM_PORT_ARB_PERF_EN
        test_perf();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sequences the single-port 16-bit unified memory of the pipelined core between two requesters: instruction fetch (IF stage) and data access (MEM stage, driven by MemRead/MemWrite from the control unit). Data has fixed priority over fetch. Drives a global stall to the pipeline registers while an access is outstanding. Sits between the IF/MEM stages and the memory block.

Parameters:
MEM_LATENCY, 1, cycles mem_en/mem_addr are held before mem_rdata is sampled (legal range 1..15).
AW, 16, address width.
DW, 16, data width.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
if_req  in  1  fetch request; held until if_ready.
if_addr  in  AW  fetch address.
if_rdata  out  DW  fetched instruction; valid while if_ready=1.
if_ready  out  1  one-cycle completion pulse for fetch.
d_read  in  1  data read request (MemRead); held until d_ready.
d_write  in  1  data write request (MemWrite); held until d_ready.
d_addr  in  AW  data address (ALU result).
d_wdata  in  DW  store data.
d_rdata  out  DW  load data; valid while d_ready=1.
d_ready  out  1  one-cycle completion pulse for data.
mem_en  out  1  memory enable.
mem_we  out  1  memory write enable.
mem_addr  out  AW  memory address.
mem_wdata  out  DW  memory write data.
mem_rdata  in  DW  memory read data.
stall  out  1  freeze PC and pipeline registers.

Behaviour:
- States: IDLE, ACCESS, DONE. Owner register: NONE, IFETCH, DATA.
- Reset (sync): state=IDLE, owner=NONE, wait counter=0; all outputs 0 (if_rdata, d_rdata=0).
- IDLE: if d_read|d_write -> latch d_addr, d_wdata, we=d_write, owner=DATA, counter=MEM_LATENCY, go ACCESS. Else if if_req -> latch if_addr, we=0, owner=IFETCH, go ACCESS. Else stay.
- d_read and d_write both high: treated as write; read ignored.
- ACCESS: mem_en=1, mem_we/mem_addr/mem_wdata from latched registers, stable for all MEM_LATENCY cycles. Counter decrements each cycle; on the cycle it equals 1, mem_rdata captured into owner's rdata register, go DONE.
- DONE: owner's ready=1 for exactly this cycle, mem_en=0; requests ignored this cycle (requester still holding its line); go IDLE.
- Timing (MEM_LATENCY=L): request seen in IDLE at cycle N; mem_en high N+1..N+L; ready at N+L+1; next grant decided at N+L+2. Throughput one access per L+2 cycles.
- Writes: d_ready pulses; d_rdata is also updated with mem_rdata and is don't-care for writes.
- Request dropped mid-ACCESS: access completes, ready still pulses.
- stall = (if_req | d_read | d_write) & ~if_ready & ~d_ready (combinational from registered state/inputs).
- Fetch pending while data owns the port: fetch waits; never starved beyond one data access because the pipeline stalls and issues no new data requests.
- Reset in any state: returns to IDLE next edge, mem_en=0, partial access discarded, no ready pulse.

Optional Feature:
MEM_PORT_ARB_PERF_EN: adds outputs perf_if_cnt, perf_d_cnt, perf_stall_cnt (16-bit each, saturating at 0xFFFF, cleared by reset), incremented on if_ready, on d_ready, and on each cycle stall=1 respectively. Without the macro the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package: state encoding (IDLE/ACCESS/DONE), owner encoding (NONE/IFETCH/DATA), default widths AW/DW.
- One natural sub-module: mem_port_wait_cnt (loadable down-counter with terminal flag), reused for the wait-state count.

Test Plan:
- Reset, then if_req=1, if_addr=0x0010, mem returns 0x3A45, L=1 -> mem_en at cycle 1, if_ready and if_rdata=0x3A45 at cycle 2, stall high cycles 0-1.
- if_req and d_read together in IDLE, d_addr=0x0200 -> data granted first, d_ready at N+L+1, fetch granted at N+L+2, if_ready at N+2L+3.
- d_write=1, d_addr=0x0040, d_wdata=0xBEEF, L=3 -> mem_we=1, mem_addr=0x0040, mem_wdata=0xBEEF held 3 cycles, single d_ready pulse.
- d_read=d_write=1 -> write performed (mem_we=1), exactly one d_ready.
- Reset asserted mid-ACCESS (L=4, cycle 2) -> next cycle mem_en=0, no ready pulse, IDLE; a new request afterwards completes normally.
- With MEM_PORT_ARB_PERF_EN: 3 fetches, 2 loads at L=1 -> perf_if_cnt=3, perf_d_cnt=2, perf_stall_cnt=10.
